// File: rtl/csr_exc_ctrl_pkg.sv
// csr_exc_ctrl_pkg: op codes, cause codes, CSR addresses, mstatus fields and FSM states for the CSR/exception controller
package csr_exc_ctrl_pkg;

    localparam logic [2:0] CSR_OP_RW      = 3'd0;
    localparam logic [2:0] CSR_OP_RS      = 3'd1;
    localparam logic [2:0] CSR_OP_RC      = 3'd2;
    localparam logic [2:0] CSR_OP_ECALL   = 3'd3;
    localparam logic [2:0] CSR_OP_EBREAK  = 3'd4;
    localparam logic [2:0] CSR_OP_MRET    = 3'd5;
    localparam logic [2:0] CSR_OP_ILLEGAL = 3'd6;

    localparam logic [31:0] EXC_ECALL_M    = 32'd11;
    localparam logic [31:0] EXC_BREAKPOINT = 32'd3;
    localparam logic [31:0] EXC_ILLEGAL    = 32'd2;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;
    localparam int MSTATUS_MPP  = 11;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_EXEC      = 4'd1,
        ST_T_MEPC    = 4'd2,
        ST_T_MCAUSE  = 4'd3,
        ST_T_MTVAL   = 4'd4,
        ST_T_MSTATUS = 4'd5,
        ST_T_JUMP    = 4'd6,
        ST_R_MSTATUS = 4'd7,
        ST_R_JUMP    = 4'd8
    } state_e;

    function automatic logic [31:0] trap_cause(input logic [2:0] op);
        return op == CSR_OP_ECALL ? EXC_ECALL_M : op == CSR_OP_EBREAK ? EXC_BREAKPOINT : EXC_ILLEGAL;
    endfunction

    function automatic logic [31:0] trap_tval(input logic [2:0] op, input logic [31:0] pc, input logic [31:0] inst);
        return op == CSR_OP_EBREAK ? pc : op == CSR_OP_ILLEGAL ? inst : 32'd0;
    endfunction

    // Trap entry: stash MIE in MPIE, disable interrupts, record M-mode as previous privilege.
    function automatic logic [31:0] trap_mstatus(input logic [31:0] s);
        logic [31:0] r;
        r = s;
        r[MSTATUS_MPIE] = s[MSTATUS_MIE];
        r[MSTATUS_MIE] = 1'b0;
        r[MSTATUS_MPP +: 2] = 2'b11;
        return r;
    endfunction

    // Trap return: restore MIE from MPIE, set MPIE, keep M-mode as previous privilege.
    function automatic logic [31:0] mret_mstatus(input logic [31:0] s);
        logic [31:0] r;
        r = s;
        r[MSTATUS_MIE] = s[MSTATUS_MPIE];
        r[MSTATUS_MPIE] = 1'b1;
        r[MSTATUS_MPP +: 2] = 2'b11;
        return r;
    endfunction

endpackage

// File: rtl/csr_alu.sv
// csr_alu: new CSR value and write enable for CSRRW/CSRRS/CSRRC
module csr_alu
    import csr_exc_ctrl_pkg::*;
(
    input  logic [2:0]  op_i,
    input  logic [31:0] old_i,
    input  logic [31:0] operand_i,
    input  logic        rs1_nz_i,
    output logic [31:0] new_o,
    output logic        we_o
);

    // CSRRS/CSRRC with a zero source are pure reads; CSRRW always writes
    always_comb begin
        new_o = op_i == CSR_OP_RW ? operand_i : op_i == CSR_OP_RS ? (old_i | operand_i) : (old_i & ~operand_i);
        we_o  = (op_i == CSR_OP_RW) || rs1_nz_i;
    end

endmodule

// File: rtl/csr_exc_ctrl.sv
// csr_exc_ctrl: CSR read-modify-write, trap entry and MRET sequencing through one CSR write port
module csr_exc_ctrl
    import csr_exc_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [2:0]  req_op_i,
    input  logic [11:0] req_csr_addr_i,
    input  logic [31:0] req_operand_i,
    input  logic        req_rs1_nz_i,
    input  logic [4:0]  req_rd_i,
    input  logic [31:0] req_pc_i,
    input  logic [31:0] req_inst_i,
    output logic [11:0] csr_raddr_o,
    input  logic [31:0] csr_rdata_i,
    output logic [11:0] csr_waddr_o,
    output logic        csr_we_o,
    output logic [31:0] csr_wdata_o,
    output logic        rd_we_o,
    output logic [4:0]  rd_addr_o,
    output logic [31:0] rd_wdata_o,
    output logic        hold_o,
    output logic        jump_o,
    output logic [31:0] jump_addr_o
);

    state_e      state_q, state_d;
    logic [2:0]  op_q;
    logic [11:0] addr_q;
    logic [31:0] operand_q, pc_q, inst_q;
    logic        nz_q;
    logic [4:0]  rd_q;
    logic [31:0] alu_new;
    logic        alu_we;
    logic        ro_viol;

    csr_alu u_alu (
        .op_i      (op_q),
        .old_i     (csr_rdata_i),
        .operand_i (operand_q),
        .rs1_nz_i  (nz_q),
        .new_o     (alu_new),
        .we_o      (alu_we)
    );

    // Writing a CSR in the read-only quadrant turns the request into an illegal-instruction trap
    assign ro_viol = alu_we && (addr_q[11:10] == 2'b11);

    // Next-state: each trap/return step is one CSR access, so the sequence is a fixed chain
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (req_valid_i) state_d = req_op_i <= CSR_OP_RC ? ST_EXEC : req_op_i == CSR_OP_MRET ? ST_R_MSTATUS : ST_T_MEPC;
            ST_EXEC:      state_d = ro_viol ? ST_T_MEPC : ST_IDLE;
            ST_T_MEPC:    state_d = ST_T_MCAUSE;
            ST_T_MCAUSE:  state_d = ST_T_MTVAL;
            ST_T_MTVAL:   state_d = ST_T_MSTATUS;
            ST_T_MSTATUS: state_d = ST_T_JUMP;
            ST_R_MSTATUS: state_d = ST_R_JUMP;
            default:      state_d = ST_IDLE;
        endcase
    end

    // State register and request latch; op 7 is folded into ILLEGAL at capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            op_q      <= '0;
            addr_q    <= '0;
            operand_q <= '0;
            nz_q      <= 1'b0;
            rd_q      <= '0;
            pc_q      <= '0;
            inst_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && req_valid_i) begin
                op_q      <= req_op_i == 3'd7 ? CSR_OP_ILLEGAL : req_op_i;
                addr_q    <= req_csr_addr_i;
                operand_q <= req_operand_i;
                nz_q      <= req_rs1_nz_i;
                rd_q      <= req_rd_i;
                pc_q      <= req_pc_i;
                inst_q    <= req_inst_i;
            end else if (state_q == ST_EXEC && ro_viol) begin
                op_q <= CSR_OP_ILLEGAL;
            end
        end
    end

    // Port drive per state; RMW data comes straight off the combinational read path
    always_comb begin
        req_ready_o = state_q == ST_IDLE;
        hold_o      = state_q != ST_IDLE;
        csr_raddr_o = '0;
        csr_waddr_o = '0;
        csr_we_o    = 1'b0;
        csr_wdata_o = '0;
        rd_we_o     = 1'b0;
        rd_addr_o   = '0;
        rd_wdata_o  = '0;
        jump_o      = 1'b0;
        jump_addr_o = '0;
        case (state_q)
            ST_EXEC: begin
                csr_raddr_o = addr_q;
                csr_we_o    = alu_we && !ro_viol;
                csr_waddr_o = csr_we_o ? addr_q : '0;
                csr_wdata_o = csr_we_o ? alu_new : '0;
                rd_we_o     = !ro_viol && (rd_q != 5'd0);
                rd_addr_o   = rd_we_o ? rd_q : '0;
                rd_wdata_o  = rd_we_o ? csr_rdata_i : '0;
            end
            ST_T_MEPC: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = CSR_MEPC;
                csr_wdata_o = {pc_q[31:2], 2'b00};
            end
            ST_T_MCAUSE: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = CSR_MCAUSE;
                csr_wdata_o = trap_cause(op_q);
            end
            ST_T_MTVAL: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = CSR_MTVAL;
                csr_wdata_o = trap_tval(op_q, pc_q, inst_q);
            end
            ST_T_MSTATUS: begin
                csr_raddr_o = CSR_MSTATUS;
                csr_we_o    = 1'b1;
                csr_waddr_o = CSR_MSTATUS;
                csr_wdata_o = trap_mstatus(csr_rdata_i);
            end
            ST_T_JUMP: begin
                csr_raddr_o = CSR_MTVEC;
                jump_o      = 1'b1;
                jump_addr_o = {csr_rdata_i[31:2], 2'b00};
            end
            ST_R_MSTATUS: begin
                csr_raddr_o = CSR_MSTATUS;
                csr_we_o    = 1'b1;
                csr_waddr_o = CSR_MSTATUS;
                csr_wdata_o = mret_mstatus(csr_rdata_i);
            end
            ST_R_JUMP: begin
                csr_raddr_o = CSR_MEPC;
                jump_o      = 1'b1;
                jump_addr_o = {csr_rdata_i[31:2], 2'b00};
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_csr_exc_ctrl.sv
// tb_csr_exc_ctrl: directed and randomized checks of csr_exc_ctrl against a per-instruction event model
module tb_csr_exc_ctrl;

    typedef struct packed {
        logic        we;
        logic [11:0] waddr;
        logic [31:0] wdata;
        logic        rd_we;
        logic [4:0]  rd_addr;
        logic [31:0] rd_wdata;
        logic        jump;
        logic [31:0] jaddr;
        logic        hold;
        logic        ready;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic [2:0]  req_op = '0;
    logic [11:0] req_addr = '0;
    logic [31:0] req_operand = '0;
    logic        req_nz = 1'b0;
    logic [4:0]  req_rd = '0;
    logic [31:0] req_pc = '0;
    logic [31:0] req_inst = '0;
    logic        req_ready, csr_we, rd_we, hold, jump;
    logic [11:0] csr_raddr, csr_waddr;
    logic [31:0] csr_rdata, csr_wdata, rd_wdata, jump_addr;
    logic [4:0]  rd_addr;

    logic [31:0] mem [4096];
    logic [31:0] ref_csr [4096];
    logic        pre_we = 1'b0;
    logic [11:0] pre_addr = '0;
    logic [31:0] pre_data = '0;
    logic [11:0] tbl [9] = '{12'h340, 12'h300, 12'h305, 12'h341, 12'h342, 12'h343, 12'hF11, 12'hC00, 12'h7C0};

    rec_t exp_q[$];
    rec_t obs_q[$];
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // CSR register file: combinational read, write on the clock edge
    assign csr_rdata = mem[csr_raddr];
    always @(posedge clk) begin
        if (csr_we) mem[csr_waddr] <= csr_wdata;
        else if (pre_we) mem[pre_addr] <= pre_data;
    end

    csr_exc_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_op_i       (req_op),
        .req_csr_addr_i (req_addr),
        .req_operand_i  (req_operand),
        .req_rs1_nz_i   (req_nz),
        .req_rd_i       (req_rd),
        .req_pc_i       (req_pc),
        .req_inst_i     (req_inst),
        .csr_raddr_o    (csr_raddr),
        .csr_rdata_i    (csr_rdata),
        .csr_waddr_o    (csr_waddr),
        .csr_we_o       (csr_we),
        .csr_wdata_o    (csr_wdata),
        .rd_we_o        (rd_we),
        .rd_addr_o      (rd_addr),
        .rd_wdata_o     (rd_wdata),
        .hold_o         (hold),
        .jump_o         (jump),
        .jump_addr_o    (jump_addr)
    );

    task automatic set_csr(input logic [11:0] a, input logic [31:0] d);
        pre_we = 1'b1;
        pre_addr = a;
        pre_data = d;
        ref_csr[a] = d;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    // Expected per-cycle events of one instruction, from the architectural rules; updates ref_csr
    task automatic model_req(input logic [2:0] op_in, input logic [11:0] a, input logic [31:0] opd, input logic nz,
                             input logic [4:0] rd, input logic [31:0] pc, input logic [31:0] inst);
        rec_t r;
        logic [2:0] op;
        logic [31:0] old, nv, cause, tval;
        logic trap, wr;
        logic [11:0] wa [4];
        logic [31:0] wd [4];
        op = (op_in == 3'd7) ? 3'd6 : op_in;
        exp_q.delete();
        trap = (op >= 3'd3) && (op != 3'd5);
        cause = (op == 3'd3) ? 32'd11 : (op == 3'd4) ? 32'd3 : 32'd2;
        tval = (op == 3'd4) ? pc : (op == 3'd3) ? 32'd0 : inst;
        if (op <= 3'd2) begin
            old = ref_csr[a];
            wr = (op == 3'd0) || nz;
            nv = (op == 3'd0) ? opd : (op == 3'd1) ? (old | opd) : (old & ~opd);
            r = '0;
            r.hold = 1'b1;
            if (wr && a[11:10] == 2'b11) begin
                trap = 1'b1;
                cause = 32'd2;
                tval = inst;
            end else begin
                if (wr) begin r.we = 1'b1; r.waddr = a; r.wdata = nv; ref_csr[a] = nv; end
                if (rd != 5'd0) begin r.rd_we = 1'b1; r.rd_addr = rd; r.rd_wdata = old; end
            end
            exp_q.push_back(r);
        end
        if (op == 3'd5) begin
            old = ref_csr[12'h300];
            nv = (old & ~32'h1888) | (old[7] ? 32'h8 : 32'h0) | 32'h1880;
            r = '0; r.hold = 1'b1; r.we = 1'b1; r.waddr = 12'h300; r.wdata = nv;
            exp_q.push_back(r);
            ref_csr[12'h300] = nv;
            r = '0; r.hold = 1'b1; r.jump = 1'b1; r.jaddr = ref_csr[12'h341] & ~32'h3;
            exp_q.push_back(r);
        end
        if (trap) begin
            old = ref_csr[12'h300];
            wa = '{12'h341, 12'h342, 12'h343, 12'h300};
            wd = '{pc & ~32'h3, cause, tval, (old & ~32'h1888) | (old[3] ? 32'h80 : 32'h0) | 32'h1800};
            for (int i = 0; i < 4; i++) begin
                r = '0; r.hold = 1'b1; r.we = 1'b1; r.waddr = wa[i]; r.wdata = wd[i];
                exp_q.push_back(r);
                ref_csr[wa[i]] = wd[i];
            end
            r = '0; r.hold = 1'b1; r.jump = 1'b1; r.jaddr = ref_csr[12'h305] & ~32'h3;
            exp_q.push_back(r);
        end
        r = '0;
        r.ready = 1'b1;
        exp_q.push_back(r);
    endtask

    // Issue one request at an idle negedge, jitter the request bus while busy, capture every cycle
    task automatic run_req(input logic [2:0] op, input logic [11:0] a, input logic [31:0] opd, input logic nz,
                           input logic [4:0] rd, input logic [31:0] pc, input logic [31:0] inst);
        rec_t r;
        model_req(op, a, opd, nz, rd, pc, inst);
        obs_q.delete();
        req_valid = 1'b1; req_op = op; req_addr = a; req_operand = opd;
        req_nz = nz; req_rd = rd; req_pc = pc; req_inst = inst;
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            r.we = csr_we;
            r.waddr = csr_we ? csr_waddr : 12'h0;
            r.wdata = csr_we ? csr_wdata : 32'h0;
            r.rd_we = rd_we;
            r.rd_addr = rd_we ? rd_addr : 5'h0;
            r.rd_wdata = rd_we ? rd_wdata : 32'h0;
            r.jump = jump;
            r.jaddr = jump ? jump_addr : 32'h0;
            r.hold = hold;
            r.ready = req_ready;
            obs_q.push_back(r);
            if (i + 2 < exp_q.size()) begin
                req_valid = 1'($urandom); req_op = 3'($urandom); req_addr = 12'($urandom);
                req_operand = $urandom; req_nz = 1'($urandom); req_rd = 5'($urandom);
                req_pc = $urandom; req_inst = $urandom;
            end else begin
                req_valid = 1'b0;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({req_ready, hold, csr_we, rd_we, jump} !== 5'b10000) begin
            failures++;
            $display("FAIL reset_strobes got=%b exp=10000", {req_ready, hold, csr_we, rd_we, jump});
        end
        checks++;
        if ({csr_raddr, csr_waddr, csr_wdata, rd_addr, rd_wdata, jump_addr} !== '0) begin
            failures++;
            $display("FAIL reset_buses got raddr=%h waddr=%h wdata=%h jaddr=%h exp all zero", csr_raddr, csr_waddr, csr_wdata, jump_addr);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_csrrw;
        set_csr(12'h340, 32'h1234);
        run_req(3'd0, 12'h340, 32'hDEADBEEF, 1'b1, 5'd5, 32'h80, 32'h34029073);
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL csrrw cyc%0d got=%h exp=%h", i, obs_q[i], exp_q[i]); end
        end
        checks++;
        if (obs_q[0].rd_wdata !== 32'h1234 || obs_q[0].wdata !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL csrrw_values got rd=%h wdata=%h exp rd=1234 wdata=deadbeef", obs_q[0].rd_wdata, obs_q[0].wdata);
        end
        checks++;
        if (mem[12'h340] !== 32'hDEADBEEF) begin failures++; $display("FAIL csrrw_mscratch got=%h exp=deadbeef", mem[12'h340]); end
    endtask

    task automatic test_csrrs_x0;
        set_csr(12'h300, 32'h88);
        run_req(3'd1, 12'h300, 32'h0, 1'b0, 5'd3, 32'h84, 32'h300021f3);
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL csrrs_x0 cyc%0d got=%h exp=%h", i, obs_q[i], exp_q[i]); end
        end
        checks++;
        if (obs_q[0].we !== 1'b0 || obs_q[0].rd_wdata !== 32'h88) begin
            failures++;
            $display("FAIL csrrs_x0_values got we=%b rd=%h exp we=0 rd=88", obs_q[0].we, obs_q[0].rd_wdata);
        end
    endtask

    task automatic test_csrrc;
        set_csr(12'h300, 32'h88);
        run_req(3'd2, 12'h300, 32'h8, 1'b1, 5'd0, 32'h88, 32'h30043073);
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL csrrc cyc%0d got=%h exp=%h", i, obs_q[i], exp_q[i]); end
        end
        checks++;
        if (mem[12'h300] !== 32'h80) begin failures++; $display("FAIL csrrc_mstatus got=%h exp=80", mem[12'h300]); end
    endtask

    task automatic test_ecall;
        set_csr(12'h305, 32'h2001);
        set_csr(12'h300, 32'h8);
        set_csr(12'h343, 32'hFFFF);
        run_req(3'd3, 12'h0, 32'h0, 1'b0, 5'd0, 32'h100, 32'h00000073);
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL ecall cyc%0d got=%h exp=%h", i, obs_q[i], exp_q[i]); end
        end
        checks++;
        if (obs_q[4].jump !== 1'b1 || obs_q[4].jaddr !== 32'h2000 || obs_q[5].ready !== 1'b1) begin
            failures++;
            $display("FAIL ecall_jump got jump=%b addr=%h ready6=%b exp 1 2000 1", obs_q[4].jump, obs_q[4].jaddr, obs_q[5].ready);
        end
        checks++;
        if ({mem[12'h341], mem[12'h342], mem[12'h343], mem[12'h300]} !== {32'h100, 32'd11, 32'h0, 32'h1880}) begin
            failures++;
            $display("FAIL ecall_csrs got mepc=%h mcause=%h mtval=%h mstatus=%h exp 100 b 0 1880",
                     mem[12'h341], mem[12'h342], mem[12'h343], mem[12'h300]);
        end
    endtask

    task automatic test_illegal_ro;
        set_csr(12'hF11, 32'h5A5A);
        run_req(3'd0, 12'hF11, 32'h77, 1'b1, 5'd7, 32'h40, 32'hF11393F3);
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL illegal_ro cyc%0d got=%h exp=%h", i, obs_q[i], exp_q[i]); end
        end
        checks++;
        if (obs_q[0].rd_we !== 1'b0 || obs_q[0].we !== 1'b0) begin
            failures++;
            $display("FAIL illegal_ro_nowrite got rd_we=%b we=%b exp 0 0", obs_q[0].rd_we, obs_q[0].we);
        end
        checks++;
        if ({mem[12'h341], mem[12'h342], mem[12'h343], mem[12'hF11]} !== {32'h40, 32'd2, 32'hF11393F3, 32'h5A5A}) begin
            failures++;
            $display("FAIL illegal_ro_csrs got mepc=%h mcause=%h mtval=%h mvendorid=%h exp 40 2 f11393f3 5a5a",
                     mem[12'h341], mem[12'h342], mem[12'h343], mem[12'hF11]);
        end
    endtask

    task automatic test_mret;
        set_csr(12'h300, 32'h1880);
        set_csr(12'h341, 32'h104);
        run_req(3'd5, 12'h0, 32'h0, 1'b0, 5'd0, 32'h2010, 32'h30200073);
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL mret cyc%0d got=%h exp=%h", i, obs_q[i], exp_q[i]); end
        end
        checks++;
        if (obs_q[0].wdata !== 32'h1888 || obs_q[1].jaddr !== 32'h104 || obs_q[1].jump !== 1'b1) begin
            failures++;
            $display("FAIL mret_values got mstatus=%h jump=%b addr=%h exp 1888 1 104", obs_q[0].wdata, obs_q[1].jump, obs_q[1].jaddr);
        end
    endtask

    task automatic test_reset_mid_trap;
        set_csr(12'h342, 32'h55);
        set_csr(12'h300, 32'h8);
        set_csr(12'h305, 32'h3000);
        req_valid = 1'b1; req_op = 3'd3; req_pc = 32'h200; req_rd = 5'd0; req_inst = 32'h73;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (csr_we !== 1'b1 || csr_waddr !== 12'h342) begin
            failures++;
            $display("FAIL mid_trap_mcause got we=%b waddr=%h exp 1 342", csr_we, csr_waddr);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({req_ready, hold, jump, csr_we} !== 4'b1000) begin
            failures++;
            $display("FAIL mid_trap_reset got ready/hold/jump/we=%b exp=1000", {req_ready, hold, jump, csr_we});
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (jump !== 1'b0 || hold !== 1'b0 || req_ready !== 1'b1) begin
                failures++;
                $display("FAIL mid_trap_after cyc%0d got jump=%b hold=%b ready=%b exp 0 0 1", i, jump, hold, req_ready);
            end
        end
        checks++;
        if (mem[12'h341] !== 32'h200 || mem[12'h342] !== 32'h55) begin
            failures++;
            $display("FAIL mid_trap_csrs got mepc=%h mcause=%h exp 200 55", mem[12'h341], mem[12'h342]);
        end
        ref_csr[12'h341] = 32'h200;
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 9; i++) set_csr(tbl[i], $urandom);
        for (int n = 0; n < 60; n++) begin
            run_req(3'($urandom), tbl[$urandom_range(0, 8)], $urandom, 1'($urandom_range(0, 3) != 0),
                    5'($urandom), $urandom, $urandom);
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL random req%0d cyc%0d got=%h exp=%h", n, i, obs_q[i], exp_q[i]); end
            end
        end
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (mem[tbl[i]] !== ref_csr[tbl[i]]) begin
                failures++;
                $display("FAIL random_final csr=%h got=%h exp=%h", tbl[i], mem[tbl[i]], ref_csr[tbl[i]]);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) ref_csr[i] = '0;
        test_reset;
        test_csrrw;
        test_csrrs_x0;
        test_csrrc;
        test_ecall;
        test_illegal_ro;
        test_mret;
        test_reset_mid_trap;
        test_back_to_back;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
